// File: rtl/cpu_defs.sv
// cpu_defs: shared constants and state encoding for the fetch stage.
// Imported by fetch_stage and fetch_skid_buf.
package cpu_defs;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry {instr, pc} holding register.
// Ports: load/unload/clear controls, in_instr/in_pc data, full/instr/pc state.
module fetch_skid_buf
    import cpu_defs::*;
#(
    parameter int unsigned W = INSTR_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] in_instr,
    input  logic [W-1:0] in_pc,
    output logic         full,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, one-outstanding SRAM fetch, registered decode output.
// Ports: clk/resetn, inst_* SRAM req/addr_ok/data_ok, redirect_*, id_* to decode.
module fetch_stage
    import cpu_defs::*;
#(
    parameter int unsigned       DATA_W   = INSTR_W,
    parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              inst_req,
    output logic [DATA_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_pc_plus4
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d, pc_next;
    logic              cancel_q, cancel_d;
    logic              out_free;
    logic              take_mem, take_skid;
    logic              skid_load, skid_unload;
    logic              skid_full;
    logic [DATA_W-1:0] skid_instr, skid_pc;

    assign out_free  = !id_valid || id_ready;
    assign pc_next   = pc_q + DATA_W'(4);
    assign inst_addr = pc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cancel_d    = cancel_q;
        inst_req    = 1'b0;
        take_mem    = 1'b0;
        take_skid   = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        unique case (state_q)
            S_REQ: begin
                inst_req = resetn && out_free;
                if (inst_req && inst_addr_ok) begin
                    state_d  = S_WAIT;
                    // a redirect here still lets the old request go out
                    cancel_d = redirect_valid;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (cancel_q || redirect_valid) begin
                        state_d  = S_REQ;
                        cancel_d = 1'b0;
                    end else if (out_free) begin
                        take_mem = 1'b1;
                        pc_d     = pc_next;
                        state_d  = S_REQ;
                    end else begin
                        skid_load = 1'b1;
                        pc_d      = pc_next;
                        state_d   = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    cancel_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (id_ready && skid_full) begin
                    take_skid   = 1'b1;
                    skid_unload = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid)
            pc_d = redirect_pc & ~DATA_W'(3);
    end

    fetch_skid_buf #(.W(DATA_W)) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (redirect_valid),
        .in_instr (inst_rdata),
        .in_pc    (pc_q),
        .full     (skid_full),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (take_mem) begin
            id_valid    <= 1'b1;
            id_instr    <= inst_rdata;
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_next;
        end else if (take_skid) begin
            id_valid    <= 1'b1;
            id_instr    <= skid_instr;
            id_pc       <= skid_pc;
            id_pc_plus4 <= skid_pc + DATA_W'(4);
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule
